// File: rtl/linebuf_pkg.sv
// Shared types and widths for the ping-pong line-buffer controller.
package linebuf_pkg;

    // Fill FSM states: request a line, accept bytes, wait for the line swap.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    localparam int BYTE_IDX_W = 7;
    localparam int NIB_W      = 4;
    localparam int RAM_ADA_W  = 8;
    localparam int RAM_ADB_W  = 9;

endpackage

// File: rtl/linebuf_scan.sv
// Scanout side of the line buffer: pixel counter, optional pixel doubling
// (LINEBUF_PIXEL_DOUBLE_EN), port B addressing and the 1-cycle output stage.
// pix_en is a one-cycle strobe; pix_valid_o follows it exactly one cycle later.
module linebuf_scan
    import linebuf_pkg::*;
#(
    parameter int                LINE_PIXELS = 256,
    parameter logic [NIB_W-1:0]  BG_COLOR    = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_start_i,
    input  logic                  pix_en_i,
    input  logic                  front_i,
    input  logic                  front_valid_i,
    input  logic [NIB_W-1:0]      ram_doutb_i,
    output logic [RAM_ADB_W-1:0]  ram_adb_o,
    output logic                  ram_ceb_o,
    output logic [NIB_W-1:0]      pix_out_o,
    output logic                  pix_valid_o
);

    localparam logic [8:0] CNT_LIMIT = 9'(LINE_PIXELS);

    logic [8:0]       pix_cnt_q, pix_cnt_d, cnt_eff;
    logic             in_range, step;
    logic             pix_valid_q, rd_ok_q;
    logic [NIB_W-1:0] hold_q;

`ifdef LINEBUF_PIXEL_DOUBLE_EN
    logic phase_q, phase_d, phase_eff;

    // Phase bit: the counter advances only on the second pix_en of each pair.
    always_comb begin
        phase_eff = line_start_i ? 1'b0 : phase_q;
        phase_d   = pix_en_i ? ~phase_eff : phase_eff;
        step      = phase_eff;
    end

    // Phase register, cleared by reset and by every line_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= 1'b0;
        else        phase_q <= phase_d;
    end
`else
    assign step = 1'b1;
`endif

    // A line_start in the same cycle as pix_en restarts the line before the read.
    always_comb begin
        cnt_eff   = line_start_i ? 9'd0 : pix_cnt_q;
        in_range  = (cnt_eff < CNT_LIMIT);
        pix_cnt_d = cnt_eff;
        if (pix_en_i && step && (cnt_eff != CNT_LIMIT))
            pix_cnt_d = cnt_eff + 9'd1;
        ram_ceb_o = pix_en_i;
        ram_adb_o = pix_en_i ? {front_i, cnt_eff[7:0]} : '0;
    end

    // Counter and the read-qualifier pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q   <= '0;
            pix_valid_q <= 1'b0;
            rd_ok_q     <= 1'b0;
            hold_q      <= BG_COLOR;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            pix_valid_q <= pix_en_i;
            rd_ok_q     <= pix_en_i && in_range && front_valid_i;
            if (pix_valid_q) hold_q <= pix_out_o;
        end
    end

    // BRAM data arrives the cycle after the read; hold the last pixel otherwise.
    always_comb begin
        pix_out_o = hold_q;
        if (pix_valid_q) pix_out_o = rd_ok_q ? ram_doutb_i : BG_COLOR;
    end

    assign pix_valid_o = pix_valid_q;

endmodule

// File: rtl/linebuf_ctrl.sv
// Ping-pong line-buffer controller: fills the back bank over BRAM port A,
// scans the front bank out over port B, swaps banks on line_start.
// Upstream handshake: a byte transfers on a clock edge where fill_valid and
// fill_ready are both high. Optional macro: LINEBUF_PIXEL_DOUBLE_EN.
module linebuf_ctrl
    import linebuf_pkg::*;
#(
    parameter int                LINE_PIXELS = 256,
    parameter logic [NIB_W-1:0]  BG_COLOR    = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_start,
    input  logic                  pix_en,
    output logic [NIB_W-1:0]      pix_out,
    output logic                  pix_valid,
    output logic                  fill_req,
    input  logic [7:0]            fill_data,
    input  logic                  fill_valid,
    output logic                  fill_ready,
    output logic                  underrun,
    input  logic                  clear_underrun,
    output logic [RAM_ADA_W-1:0]  ram_ada,
    output logic [7:0]            ram_dina,
    output logic                  ram_cea,
    output logic                  ram_wrea,
    output logic [RAM_ADB_W-1:0]  ram_adb,
    output logic                  ram_ceb,
    input  logic [NIB_W-1:0]      ram_doutb,
    output fill_state_e           dbg_fill_state
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(LINE_PIXELS / 2 - 1);

    fill_state_e           state_q;
    logic [BYTE_IDX_W-1:0] byte_cnt_q;
    logic                  front_q, front_d, front_valid_q, front_valid_d;
    logic                  fill_req_q, fill_ready_q, underrun_q;
    logic                  accept, last_accept, line_done, line_under;

    // Handshake decode and bank-swap decision; a final byte landing with
    // line_start still completes the line.
    always_comb begin
        accept        = fill_valid && fill_ready_q;
        last_accept   = accept && (byte_cnt_q == LAST_IDX);
        line_done     = line_start && ((state_q == DONE) || last_accept);
        line_under    = line_start && !line_done;
        front_d       = line_done ? ~front_q : front_q;
        front_valid_d = front_valid_q || line_done;
        ram_cea       = accept;
        ram_wrea      = accept;
        ram_ada       = accept ? {~front_q, byte_cnt_q} : '0;
        ram_dina      = accept ? fill_data : '0;
    end

    // Fill FSM with bank selection and sticky underrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= REQ;
            byte_cnt_q    <= '0;
            front_q       <= 1'b0;
            front_valid_q <= 1'b0;
            fill_req_q    <= 1'b0;
            fill_ready_q  <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            front_q       <= front_d;
            front_valid_q <= front_valid_d;
            fill_req_q    <= 1'b0;
            if (clear_underrun)  underrun_q <= 1'b0;
            else if (line_under) underrun_q <= 1'b1;
            if (line_start) begin
                state_q      <= REQ;
                fill_ready_q <= 1'b0;
            end else begin
                case (state_q)
                    REQ: begin
                        fill_req_q   <= 1'b1;
                        fill_ready_q <= 1'b1;
                        byte_cnt_q   <= '0;
                        state_q      <= FILL;
                    end
                    FILL: begin
                        if (accept) begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            if (last_accept) begin
                                fill_ready_q <= 1'b0;
                                state_q      <= DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign fill_req       = fill_req_q;
    assign fill_ready     = fill_ready_q;
    assign underrun       = underrun_q;
    assign dbg_fill_state = state_q;

    linebuf_scan #(
        .LINE_PIXELS (LINE_PIXELS),
        .BG_COLOR    (BG_COLOR)
    ) u_scan (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_start_i  (line_start),
        .pix_en_i      (pix_en),
        .front_i       (front_d),
        .front_valid_i (front_valid_d),
        .ram_doutb_i   (ram_doutb),
        .ram_adb_o     (ram_adb),
        .ram_ceb_o     (ram_ceb),
        .pix_out_o     (pix_out),
        .pix_valid_o   (pix_valid)
    );

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Bench for linebuf_ctrl: behavioural BRAM, fill driver, pixel scoreboard.
module tb_linebuf_ctrl;
    import linebuf_pkg::*;

`ifdef LINEBUF_PIXEL_DOUBLE_EN
    localparam int DUP = 2;
`else
    localparam int DUP = 1;
`endif

    logic        clk, rst_n, line_start, pix_en, fill_valid, clear_underrun;
    logic [7:0]  fill_data;
    logic [3:0]  pix_out, ram_doutb;
    logic        pix_valid, fill_req, fill_ready, underrun;
    logic [7:0]  ram_ada, ram_dina;
    logic        ram_cea, ram_wrea, ram_ceb;
    logic [8:0]  ram_adb;
    fill_state_e dbg_fill_state;

    logic [7:0]  mem [256];
    logic [3:0]  exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          req_cnt  = 0;
    logic        pe_d     = 1'b0;
    logic        mon_en   = 1'b0;

    linebuf_ctrl dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .pix_en(pix_en),
        .pix_out(pix_out), .pix_valid(pix_valid), .fill_req(fill_req),
        .fill_data(fill_data), .fill_valid(fill_valid), .fill_ready(fill_ready),
        .underrun(underrun), .clear_underrun(clear_underrun),
        .ram_ada(ram_ada), .ram_dina(ram_dina), .ram_cea(ram_cea), .ram_wrea(ram_wrea),
        .ram_adb(ram_adb), .ram_ceb(ram_ceb), .ram_doutb(ram_doutb),
        .dbg_fill_state(dbg_fill_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural mixed-width BRAM: 8-bit write port, 4-bit read port, 1-cycle read
    always @(posedge clk) begin
        if (ram_cea && ram_wrea) mem[ram_ada] <= ram_dina;
        if (ram_ceb) ram_doutb <= ram_adb[0] ? mem[ram_adb[8:1]][7:4] : mem[ram_adb[8:1]][3:0];
    end

    always @(posedge clk) begin
        pe_d <= pix_en;
        if (fill_req) req_cnt <= req_cnt + 1;
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            chk("pix_valid_timing", int'(pix_valid), int'(pe_d));
            if (pix_valid) begin
                if (exp_q.size() == 0) chk("pix_unexpected", 1, 0);
                else chk("pix_out", int'(pix_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected nibble: sel 0 = background, 1 = bytes 0x10+k, 2 = bytes 0x3C
    function automatic logic [3:0] exp_nib(input int sel, input int idx);
        logic [7:0] b;
        if (sel == 0 || idx >= 256) return 4'h0;
        b = (sel == 1) ? 8'(16 + idx / 2) : 8'h3C;
        return (idx % 2 == 1) ? b[7:4] : b[3:0];
    endfunction

    task automatic fill_bytes(input int n, input logic [7:0] base, input bit incr, input bit bank);
        int guard;
        for (int k = 0; k < n; k++) begin
            fill_data  = incr ? 8'(int'(base) + k) : base;
            fill_valid = 1'b1;
            guard = 0;
            while (!fill_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!fill_ready) begin
                chk("fill_ready_timeout", 0, 1);
                fill_valid = 1'b0;
                return;
            end
            #1;
            chk("ram_porta", int'({ram_cea, ram_wrea, ram_ada, ram_dina}),
                int'({1'b1, 1'b1, bank, 7'(k), fill_data}));
            tick();
        end
        fill_valid = 1'b0;
    endtask

    task automatic pix_run(input int n, input int sel, input bit bank, input bit with_start);
        int idx;
        for (int i = 0; i < n; i++) begin
            idx    = i / DUP;
            pix_en = 1'b1;
            if (with_start && i == 0) begin
                line_start = 1'b1;
                fill_data  = 8'h3C;
                fill_valid = 1'b1;
            end
            exp_q.push_back(exp_nib(sel, idx));
            #1;
            chk("ram_portb", int'({ram_ceb, ram_adb}),
                int'({1'b1, bank, (idx >= 256) ? 8'h00 : 8'(idx)}));
            tick();
            line_start = 1'b0;
            fill_valid = 1'b0;
        end
        pix_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_line_start();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    initial begin
        int guard;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        rst_n = 1'b0; line_start = 1'b0; pix_en = 1'b0; fill_valid = 1'b0;
        fill_data = 8'h00; clear_underrun = 1'b0;
        #22;
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_out", int'(pix_out), 0);
        chk("rst_fill_req", int'(fill_req), 0);
        chk("rst_fill_ready", int'(fill_ready), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_ram_ctl", int'({ram_cea, ram_wrea, ram_ceb}), 0);
        chk("rst_ram_addr", int'({ram_ada, ram_dina, ram_adb}), 0);
        chk("rst_state", int'(dbg_fill_state), int'(REQ));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        chk("first_fill_req", req_cnt, 1);
        chk("filling_ready", int'(fill_ready), 1);

        // line_start before any fill completes
        pulse_line_start();
        chk("early_underrun", int'(underrun), 1);
        pix_run(256 * DUP, 0, 1'b0, 1'b0);
        chk("refill_req", req_cnt, 2);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        chk("underrun_cleared", int'(underrun), 0);

        // full line into bank 1, swap, scan past the end of the line
        fill_bytes(128, 8'h10, 1'b1, 1'b1);
        chk("done_ready_low", int'(fill_ready), 0);
        chk("done_state", int'(dbg_fill_state), int'(DONE));
        pulse_line_start();
        chk("swap_no_underrun", int'(underrun), 0);
        pix_run(300 * DUP, 1, 1'b1, 1'b0);
        chk("line_req", req_cnt, 3);

        // stalled fill of bank 0, then line_start: old line repeats
        fill_bytes(100, 8'hEE, 1'b0, 1'b0);
        pulse_line_start();
        chk("stall_underrun", int'(underrun), 1);
        pix_run(256 * DUP, 1, 1'b1, 1'b0);
        chk("underrun_sticky", int'(underrun), 1);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        chk("underrun_clear2", int'(underrun), 0);

        // final byte, line_start and pix_en all in one cycle
        fill_bytes(127, 8'h3C, 1'b0, 1'b0);
        pix_run(4 * DUP, 2, 1'b0, 1'b1);
        chk("race_no_underrun", int'(underrun), 0);
        guard = 0;
        while (req_cnt < 5 && guard < 20) begin
            tick();
            guard++;
        end
        chk("race_req", req_cnt, 5);

        tick();
        chk("queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
